// File: rtl/sonic_blocksync.sv
// 66-bit receive block synchronizer: hunts for the sync-header bit offset, then forwards aligned blocks and drives lock.
// Latency: data_out/valid_out one clock after the valid_in cycle; the block emitted is the one ending in the previous word.
// Backpressure: none; a word is accepted on every valid_in, and gaps freeze the search state.
module sonic_blocksync #(
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [65:0] data_in,
    input  logic        valid_in,
    output logic [65:0] data_out,
    output logic        valid_out,
    output logic        lock,
    output logic [6:0]  offset,
    output logic [15:0] slip_count
);

    localparam logic [6:0] CNT_MAX   = 7'(SH_CNT_MAX);
    localparam logic [4:0] INVLD_MAX = 5'(SH_INVLD_MAX);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_TEST,
        ST_SLIP
    } state_t;

    state_t      state;
    logic [65:0] prev;
    logic [6:0]  sh_cnt;
    logic [4:0]  sh_invld_cnt;
    logic [65:0] cand;
    logic        sh_ok;
    logic [6:0]  cnt_nxt;
    logic [4:0]  invld_nxt;

    // Candidate block is a 66-bit window into {data_in, prev} starting at offset.
    always_comb begin
        cand      = 66'({data_in, prev} >> offset);
        sh_ok     = cand[1] ^ cand[0];
        cnt_nxt   = sh_cnt + 7'd1;
        invld_nxt = sh_invld_cnt + {4'd0, ~sh_ok};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_INIT;
            prev         <= '0;
            data_out     <= '0;
            valid_out    <= 1'b0;
            lock         <= 1'b0;
            offset       <= '0;
            slip_count   <= '0;
            sh_cnt       <= '0;
            sh_invld_cnt <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                prev     <= data_in;
                data_out <= cand;
            end

            case (state)
                ST_INIT: begin
                    sh_cnt       <= '0;
                    sh_invld_cnt <= '0;
                    state        <= ST_TEST;
                end

                ST_TEST: begin
                    if (valid_in) begin
                        sh_cnt       <= cnt_nxt;
                        sh_invld_cnt <= invld_nxt;
                        if (!lock) begin
                            if (!sh_ok) begin
                                state <= ST_SLIP;
                            end else if (cnt_nxt == CNT_MAX) begin
                                lock         <= 1'b1;
                                sh_cnt       <= '0;
                                sh_invld_cnt <= '0;
                            end
                        end else begin
                            // Invalid threshold is tested first so it beats a coincident window end.
                            if (invld_nxt == INVLD_MAX) begin
                                lock  <= 1'b0;
                                state <= ST_SLIP;
                            end else if (cnt_nxt == CNT_MAX) begin
                                sh_cnt       <= '0;
                                sh_invld_cnt <= '0;
                            end
                        end
                    end
                end

                ST_SLIP: begin
                    offset       <= (offset == 7'd65) ? 7'd0 : offset + 7'd1;
                    slip_count   <= (slip_count == 16'hFFFF) ? slip_count : slip_count + 16'd1;
                    sh_cnt       <= '0;
                    sh_invld_cnt <= '0;
                    lock         <= 1'b0;
                    state        <= ST_TEST;
                end

                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sonic_blocksync.sv
// Directed bench for sonic_blocksync: serializes 66-bit blocks at a chosen true bit offset into gearbox words.
// Latency: expected blocks are queued when a word is driven and popped one clock later when the block comes out.
// Backpressure: none; valid_in gaps are inserted explicitly by the stimulus.
module tb_sonic_blocksync;

    logic        clock;
    logic        reset;
    logic [65:0] data_in;
    logic        valid_in;
    logic [65:0] data_out;
    logic        valid_out;
    logic        lock;
    logic [6:0]  offset;
    logic [15:0] slip_count;

    int          n_checks = 0;
    int          n_err    = 0;
    int          t_off    = 0;
    bit          chk      = 0;
    logic [65:0] blk_prev = '0;
    logic [65:0] sb[$];

    sonic_blocksync dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .lock       (lock),
        .offset     (offset),
        .slip_count (slip_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle; the expected output block goes to the scoreboard if checking is on.
    task automatic send(input logic [65:0] w, input logic v, input logic [65:0] e);
        logic [65:0] exp_d;
        data_in  = w;
        valid_in = v;
        if (v && chk) sb.push_back(e);
        @(posedge clock);
        #1;
        check("valid_out", 66'(valid_out), 66'(v));
        if (sb.size() > 0) begin
            exp_d = sb.pop_front();
            check("data_out", data_out, exp_d);
        end
    endtask

    function automatic logic [1:0] good_hdr();
        return 2'($urandom_range(1, 2));
    endfunction

    // Next block of the serial stream; the word carries the tail of the previous block in its low t_off bits.
    task automatic blk(input logic [1:0] hdr, input bit rnd);
        logic [65:0]  cur;
        logic [131:0] pair;
        cur  = {rnd ? {$urandom, $urandom} : 64'h0, hdr};
        pair = {cur, blk_prev} >> (66 - t_off);
        send(pair[65:0], 1'b1, blk_prev);
        blk_prev = cur;
    endtask

    task automatic idle();
        send(66'h0, 1'b0, 66'h0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        sb.delete();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset    = 1'b0;
        blk_prev = '0;
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        #2;
        check("rst_data_out", data_out, 66'h0);
        check("rst_valid_out", 66'(valid_out), 66'(0));
        check("rst_lock", 66'(lock), 66'(0));
        check("rst_offset", 66'(offset), 66'(0));
        check("rst_slip_count", 66'(slip_count), 66'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Aligned stream, true offset 0; first word lands in the INIT cycle.
        t_off = 0;
        chk   = 1;
        for (int i = 0; i <= 64; i++) begin
            blk(good_hdr(), 1);
            if (i == 63) check("aligned_lock_pre", 66'(lock), 66'(0));
            if (i == 64) check("aligned_lock", 66'(lock), 66'(1));
        end
        check("aligned_slips", 66'(slip_count), 66'(0));
        check("aligned_offset", 66'(offset), 66'(0));

        // 15 bad headers in one window keep lock.
        for (int i = 0; i < 64; i++)
            blk((i >= 2 && i <= 30 && i % 2 == 0) ? 2'b00 : good_hdr(), 1);
        check("err15_lock", 66'(lock), 66'(1));
        check("err15_slips", 66'(slip_count), 66'(0));

        // 16 bad headers in the next window drop lock on the 16th.
        for (int j = 0; j <= 17; j++) begin
            blk((j < 16) ? 2'b00 : good_hdr(), 1);
            if (j == 15) check("err16_lock_pre", 66'(lock), 66'(1));
            if (j == 16) begin
                check("err16_lock", 66'(lock), 66'(0));
                check("err16_offset_pre", 66'(offset), 66'(0));
            end
            if (j == 17) begin
                check("err16_offset", 66'(offset), 66'(1));
                check("err16_slips", 66'(slip_count), 66'(1));
            end
        end
        chk = 0;

        // Misaligned stream, true offset 17, header 10, zero payload.
        do_reset();
        t_off = 17;
        n     = 0;
        do begin
            blk(2'b10, 0);
            n++;
        end while (!lock && n < 500);
        check("mis_lock", 66'(lock), 66'(1));
        check("mis_steps", 66'(n), 66'(1 + 2 * 17 + 64));
        check("mis_offset", 66'(offset), 66'(17));
        check("mis_slips", 66'(slip_count), 66'(17));
        chk = 1;
        for (int i = 0; i < 8; i++) begin
            blk(2'b10, 0);
            check("mis_block", data_out, {64'h0, 2'b10});
        end
        chk = 0;

        // Wrap: true offset 65 found after 65 slips, next loss wraps to 0.
        do_reset();
        t_off = 65;
        n     = 0;
        do begin
            blk(good_hdr(), 1);
            n++;
        end while (!lock && n < 20000);
        check("wrap_lock", 66'(lock), 66'(1));
        check("wrap_offset", 66'(offset), 66'(65));
        check("wrap_slips", 66'(slip_count), 66'(65));
        chk = 1;
        for (int i = 0; i < 8; i++) blk(good_hdr(), 1);
        n = 0;
        do begin
            blk((n < 16) ? 2'b00 : good_hdr(), 1);
            n++;
        end while (lock && n < 64);
        check("wrap_loss_steps", 66'(n), 66'(17));
        blk(good_hdr(), 1);
        chk = 0;
        check("wrap_offset0", 66'(offset), 66'(0));
        check("wrap_slips66", 66'(slip_count), 66'(66));

        // valid_in low every other cycle: lock after 64 counted blocks.
        do_reset();
        t_off = 0;
        chk   = 1;
        blk(good_hdr(), 1);
        for (int i = 1; i <= 64; i++) begin
            idle();
            if (i == 64) check("gap_idle_lock", 66'(lock), 66'(0));
            blk(good_hdr(), 1);
            if (i == 63) check("gap_lock_pre", 66'(lock), 66'(0));
            if (i == 64) check("gap_lock", 66'(lock), 66'(1));
        end
        check("gap_slips", 66'(slip_count), 66'(0));
        for (int i = 0; i < 5; i++) blk(good_hdr(), 1);
        chk = 0;

        // Asynchronous reset while locked, then relock.
        #2;
        reset = 1'b1;
        #1;
        check("arst_lock", 66'(lock), 66'(0));
        check("arst_valid_out", 66'(valid_out), 66'(0));
        check("arst_data_out", data_out, 66'h0);
        check("arst_offset", 66'(offset), 66'(0));
        check("arst_slips", 66'(slip_count), 66'(0));
        sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i <= 64; i++) begin
            blk(good_hdr(), 1);
            if (i == 63) check("relock_pre", 66'(lock), 66'(0));
            if (i == 64) check("relock", 66'(lock), 66'(1));
        end
        check("relock_slips", 66'(slip_count), 66'(0));
        chk = 1;
        for (int i = 0; i < 4; i++) blk(good_hdr(), 1);
        chk = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
